// File: rtl/first_nios2_system_sysid_checker_if.sv
// Avalon-MM read-only master bundle used by the sysid checker.
// The checker drives address/read; the slave answers with waitrequest,
// readdatavalid and readdata.
interface first_nios2_system_sysid_checker_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic        readdatavalid;
    logic [31:0] readdata;

    modport master (
        output address, read,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  address, read,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/first_nios2_system_sysid_checker.sv
// Sysid checker: on a start pulse reads word 0 (system ID) then word 1
// (build timestamp) from an Avalon-MM sysid slave. Each word is compared
// against its expected value. Every read transaction is bounded by
// TIMEOUT_CYCLES; an expired transaction ends the sequence with timeout set.
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd7,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1385656859,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic                                start_i,
    first_nios2_system_sysid_checker_if.master  master,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                id_ok_o,
    output logic                                ts_ok_o,
    output logic                                timeout_o,
    output logic [31:0]                         captured_id_o,
    output logic [31:0]                         captured_timestamp_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        FINISH  = 3'd5
    } state_e;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;

    logic       in_req, in_xact, got_rsp, rsp_id, rsp_ts, expire, enter_req;
    logic [7:0] cnt_inc;

    // A response is accepted in a WAIT state, or in a REQ state on the very
    // cycle the request is accepted (zero-latency slave). Anything else on
    // readdatavalid is stray and ignored.
    assign in_req  = (state_q == REQ_ID) || (state_q == REQ_TS);
    assign in_xact = in_req || (state_q == WAIT_ID) || (state_q == WAIT_TS);
    assign got_rsp = master.readdatavalid &&
                     ((state_q == WAIT_ID) || (state_q == WAIT_TS) ||
                      (in_req && !master.waitrequest));
    assign rsp_id  = got_rsp && ((state_q == REQ_ID) || (state_q == WAIT_ID));
    assign rsp_ts  = got_rsp && ((state_q == REQ_TS) || (state_q == WAIT_TS));

    // cnt_q counts transaction cycles already spent; this cycle is number
    // cnt_q+1, so the transaction expires at the end of cycle TIMEOUT_CYCLES.
    assign cnt_inc = cnt_q + 8'd1;
    assign expire  = in_xact && !got_rsp && (cnt_inc == TO_LIM);

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: request, wait for response, bail to FINISH on timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = REQ_ID;
            REQ_ID: begin
                if (rsp_id)                   state_d = REQ_TS;
                else if (expire)              state_d = FINISH;
                else if (!master.waitrequest) state_d = WAIT_ID;
            end
            WAIT_ID: begin
                if (rsp_id)      state_d = REQ_TS;
                else if (expire) state_d = FINISH;
            end
            REQ_TS: begin
                if (rsp_ts || expire)         state_d = FINISH;
                else if (!master.waitrequest) state_d = WAIT_TS;
            end
            WAIT_TS: if (rsp_ts || expire) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; read/address held steady across stalls
    always_comb begin
        master.read    = in_req;
        master.address = (state_q == REQ_TS);
        busy_o         = (state_q != IDLE);
        done_o         = (state_q == FINISH);
    end

    // Datapath next values: counter, sticky flags and captured words
    always_comb begin
        enter_req = ((state_d == REQ_ID) || (state_d == REQ_TS)) && (state_d != state_q);
        cnt_d     = (enter_req || !in_xact) ? 8'd0 : cnt_inc;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        timeout_d = timeout_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;
        if (state_q == IDLE && start_i) begin
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
            timeout_d = 1'b0;
        end
        if (rsp_id) begin
            cap_id_d = master.readdata;
            id_ok_d  = (master.readdata == EXPECTED_ID);
        end
        if (rsp_ts) begin
            cap_ts_d = master.readdata;
            ts_ok_d  = (master.readdata == EXPECTED_TIMESTAMP);
        end
        if (expire) timeout_d = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q     <= 8'd0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            cap_id_q  <= 32'd0;
            cap_ts_q  <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            timeout_q <= timeout_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
        end
    end

    assign id_ok_o              = id_ok_q;
    assign ts_ok_o              = ts_ok_q;
    assign timeout_o            = timeout_q;
    assign captured_id_o        = cap_id_q;
    assign captured_timestamp_o = cap_ts_q;
endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Bench for the sysid checker: a configurable Avalon slave (stall count and
// per-word read latency, -1 = never answers), a vector table with hand-derived
// expectations, a few hand-written corner sequences and a randomized run
// checked against a transaction-length model.
module tb_first_nios2_system_sysid_checker;
    localparam logic [31:0] EID = 32'd7;
    localparam logic [31:0] ETS = 32'd1385656859;
    localparam int          TO  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, id_ok, ts_ok, tmo;
    logic [31:0] cid, cts;

    first_nios2_system_sysid_checker_if av();

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID(EID), .EXPECTED_TIMESTAMP(ETS), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .master(av),
        .busy_o(busy), .done_o(done), .id_ok_o(id_ok), .ts_ok_o(ts_ok),
        .timeout_o(tmo), .captured_id_o(cid), .captured_timestamp_o(cts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // slave configuration and observation counters (written only by the slave)
    int          cfg_w = 0, cfg_lid = 1, cfg_lts = 1;
    logic [31:0] cfg_id = EID, cfg_ts = ETS;
    int          done_cnt = 0, tsreq_cnt = 0, stab_viol = 0;
    int          pend = 0, wleft = 0;
    logic [31:0] pend_data = '0;
    logic        stalled = 1'b0, paddr = 1'b0;

    logic [31:0] exp_cid = '0, exp_cts = '0;

    typedef struct {
        int          w, lid, lts;
        logic [31:0] idv, tsv;
        bit          e_id, e_ts, e_to, e_tsreq;
        int          e_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // slave: updates its outputs at each falling edge
    initial begin : slave
        int          lat;
        logic [31:0] d;
        av.waitrequest   = 1'b0;
        av.readdatavalid = 1'b0;
        av.readdata      = '0;
        forever begin
            @(negedge clk);
            av.readdatavalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    av.readdatavalid = 1'b1;
                    av.readdata      = pend_data;
                end
            end
            if (stalled && !done && !(av.read === 1'b1 && av.address === paddr)) stab_viol++;
            stalled = 1'b0;
            if (done === 1'b1) done_cnt++;
            if (av.read === 1'b1) begin
                if (av.address === 1'b1) tsreq_cnt++;
                if (wleft > 0) begin
                    av.waitrequest = 1'b1;
                    wleft--;
                    stalled = 1'b1;
                    paddr   = av.address;
                end else begin
                    av.waitrequest = 1'b0;
                    lat = av.address ? cfg_lts : cfg_lid;
                    d   = av.address ? cfg_ts  : cfg_id;
                    if (lat == 0) begin
                        av.readdatavalid = 1'b1;
                        av.readdata      = d;
                    end else if (lat > 0) begin
                        pend      = lat;
                        pend_data = d;
                    end
                    wleft = cfg_w;
                end
            end else begin
                av.waitrequest = 1'b0;
                wleft          = cfg_w;
            end
        end
    end

    // cycles one transaction takes to complete, 0 when it times out
    function automatic int xact_len(input int w, input int lat);
        if (lat < 0 || w + 1 + lat > TO) return 0;
        return w + 1 + lat;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 plain, 1 extra start during WAIT_ID, 2 extra start during FINISH
    task automatic run_seq(input string tag, input vec_t v, input int mode);
        int n, d0, t0, s0;
        bit seen;
        cfg_w = v.w; cfg_lid = v.lid; cfg_lts = v.lts; cfg_id = v.idv; cfg_ts = v.tsv;
        d0 = done_cnt; t0 = tsreq_cnt; s0 = stab_viol;
        start = 1'b1;
        n = 1;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            step();
            start = 1'b0;
            n++;
            if (n == 2) chk({tag, " busy"}, busy, 1);
            if (mode == 1 && n == 3) start = 1'b1;
            if (done === 1'b1) seen = 1'b1;
        end
        chk({tag, " done_seen"}, seen, 1);
        chk({tag, " latency"}, n, v.e_lat);
        if (mode == 2) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk({tag, " busy_after_finish_start"}, busy, 0);
        end
        repeat (3) step();
        chk({tag, " busy_idle"}, busy, 0);
        if (v.e_tsreq) exp_cid = v.idv;
        if (v.e_tsreq && !v.e_to) exp_cts = v.tsv;
        chk({tag, " done_pulses"}, done_cnt - d0, 1);
        chk({tag, " id_ok"}, id_ok, v.e_id);
        chk({tag, " ts_ok"}, ts_ok, v.e_ts);
        chk({tag, " timeout"}, tmo, v.e_to);
        chk({tag, " captured_id"}, cid, exp_cid);
        chk({tag, " captured_ts"}, cts, exp_cts);
        chk({tag, " ts_read_issued"}, (tsreq_cnt - t0) != 0, v.e_tsreq);
        chk({tag, " stable_during_wait"}, stab_viol - s0, 0);
        repeat (12) step();
    endtask

    vec_t tbl[12];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t v;
        int   k1, k2;
        tbl[0]  = '{0,  1,  1, EID,           ETS,       1, 1, 0, 1, 6};
        tbl[1]  = '{0,  1,  1, 32'd8,         ETS,       0, 1, 0, 1, 6};
        tbl[2]  = '{3,  1,  1, EID,           ETS,       1, 1, 0, 1, 12};
        tbl[3]  = '{0, -1,  1, EID,           ETS,       0, 0, 1, 0, 12};
        tbl[4]  = '{0,  0,  0, EID,           ETS,       1, 1, 0, 1, 4};
        tbl[5]  = '{2,  2,  2, EID,           ETS + 1,   1, 0, 0, 1, 12};
        tbl[6]  = '{9,  0,  0, EID,           ETS,       1, 1, 0, 1, 22};
        tbl[7]  = '{9,  1,  1, EID,           ETS,       0, 0, 1, 0, 12};
        tbl[8]  = '{0,  9,  9, EID,           ETS,       1, 1, 0, 1, 22};
        tbl[9]  = '{10, 0,  0, EID,           ETS,       0, 0, 1, 0, 12};
        tbl[10] = '{0,  1, -1, EID,           ETS,       1, 0, 1, 1, 14};
        tbl[11] = '{0,  0,  1, 32'hFFFF_FFFF, 32'd0,     0, 0, 0, 1, 5};

        rst = 1'b1;
        start = 1'b0;
        repeat (3) step();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset id_ok", id_ok, 0);
        chk("reset ts_ok", ts_ok, 0);
        chk("reset timeout", tmo, 0);
        chk("reset captured_id", cid, 0);
        chk("reset captured_ts", cts, 0);
        chk("reset read", av.read, 0);
        chk("reset address", av.address, 0);
        rst = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 12; i++) run_seq($sformatf("vec%0d", i), tbl[i], 0);

        // second start during WAIT_ID must be ignored
        v = '{0, 3, 3, EID, ETS, 1, 1, 0, 1, 10};
        run_seq("restart_wait_id", v, 1);
        // start during FINISH must be ignored
        v = '{0, 1, 1, EID, ETS, 1, 1, 0, 1, 6};
        run_seq("restart_finish", v, 2);

        for (int i = 0; i < 40; i++) begin
            v.w   = $urandom_range(0, 10);
            k1    = $urandom_range(0, 11);
            v.lid = (k1 == 11) ? -1 : k1;
            k2    = $urandom_range(0, 11);
            v.lts = (k2 == 11) ? -1 : k2;
            v.idv = $urandom_range(0, 1) ? EID : $urandom;
            v.tsv = $urandom_range(0, 1) ? ETS : $urandom;
            k1 = xact_len(v.w, v.lid);
            k2 = xact_len(v.w, v.lts);
            v.e_tsreq = (k1 != 0);
            v.e_id    = (k1 != 0) && (v.idv == EID);
            v.e_ts    = (k1 != 0) && (k2 != 0) && (v.tsv == ETS);
            v.e_to    = (k1 == 0) || (k2 == 0);
            if (k1 == 0)      v.e_lat = TO + 2;
            else if (k2 == 0) v.e_lat = k1 + TO + 2;
            else              v.e_lat = k1 + k2 + 2;
            run_seq($sformatf("rand%0d", i), v, 0);
        end

        // reset during WAIT_TS with a response still in flight
        cfg_w = 0; cfg_lid = 1; cfg_lts = 4; cfg_id = EID; cfg_ts = ETS;
        start = 1'b1;
        step();                       // C1 REQ_ID
        start = 1'b0;
        step();                       // C2 WAIT_ID
        step();                       // C3 REQ_TS
        step();                       // C4 WAIT_TS
        chk("midreset in_wait_ts busy", busy, 1);
        chk("midreset in_wait_ts read", av.read, 0);
        step();                       // C5 WAIT_TS
        rst = 1'b1;
        step();                       // C6 reset taken
        rst = 1'b0;
        chk("midreset read", av.read, 0);
        chk("midreset busy", busy, 0);
        chk("midreset captured_id", cid, 0);
        repeat (4) step();            // late readdatavalid lands in here
        chk("midreset late captured_ts", cts, 0);
        chk("midreset late ts_ok", ts_ok, 0);
        chk("midreset late id_ok", id_ok, 0);
        chk("midreset late timeout", tmo, 0);
        chk("midreset late done", done, 0);
        chk("midreset late busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/first_nios2_system_sysid_checker.md
FIRST_NIOS2_SYSTEM_SYSID_CHECKER -- requirements
Module: first_nios2_system_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 7, the expected system ID word at address 0.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 1385656859, the expected build timestamp at address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum cycles allowed per read transaction, legal range 1..255.
REQ-004 Port: clock  in  1  single clock; all logic on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: start  in  1  one-cycle pulse requesting a check sequence.
REQ-007 Port: master_address  out  1  Avalon-MM word address: 0 = ID, 1 = timestamp.
REQ-008 Port: master_read  out  1  Avalon-MM read request.
REQ-009 Port: master_waitrequest  in  1  slave stall; request held while high.
REQ-010 Port: master_readdatavalid  in  1  qualifies master_readdata.
REQ-011 Port: master_readdata  in  32  read response data.
REQ-012 Port: busy  out  1  sequence in progress.
REQ-013 Port: done  out  1  one-cycle pulse at sequence end.
REQ-014 Port: id_ok / ts_ok  out  1 each  comparison results, sticky until the next start.
REQ-015 Port: timeout  out  1  a transaction exceeded TIMEOUT_CYCLES, sticky until the next start.
REQ-016 Port: captured_id / captured_timestamp  out  32 each  last returned data.

Function
REQ-017 FSM states SHALL be: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
REQ-018 In IDLE, start=1 SHALL clear id_ok/ts_ok/timeout and move to REQ_ID next cycle; busy=1 from that cycle.
REQ-019 In REQ_ID: master_read=1, master_address=0; move to WAIT_ID on the first cycle where master_waitrequest=0.
REQ-020 In REQ_TS: master_read=1, master_address=1; move to WAIT_TS on the first cycle where master_waitrequest=0.
REQ-021 master_read SHALL be 0 in every other state; address and read SHALL stay stable while waitrequest=1.
REQ-022 In WAIT_ID, readdatavalid=1 SHALL capture readdata into captured_id, set id_ok=(readdata==EXPECTED_ID), and go to REQ_TS.
REQ-023 In WAIT_TS, readdatavalid=1 SHALL capture captured_timestamp, set ts_ok=(readdata==EXPECTED_TIMESTAMP), and go to FINISH.
REQ-024 readdatavalid arriving in the same cycle as waitrequest=0 in a REQ state (zero latency) SHALL be accepted as that transaction's response.
REQ-025 readdatavalid outside WAIT_ID/WAIT_TS, or outside a zero-latency REQ cycle, SHALL be ignored.
REQ-026 An 8-bit timeout counter SHALL clear on entry to each REQ state and increment each cycle spent in REQ_*/WAIT_*.
REQ-027 When the counter reaches TIMEOUT_CYCLES with no response, timeout SHALL be set, master_read dropped, the current ok flag left 0, and the FSM SHALL go to FINISH.
REQ-028 FINISH SHALL last one cycle with done=1, then return to IDLE with busy=0.
REQ-029 start while busy=1 SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-030 Sequence latency with zero wait states and 1-cycle read latency SHALL be 6 cycles from start to done.

Reset
REQ-031 reset=1 SHALL force IDLE: master_read=0, master_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, captured_id=0, captured_timestamp=0, counter=0.
REQ-032 Reset mid-transaction SHALL drop master_read in the next cycle and discard any later response.

Verification
REQ-033 Slave returns 7 and then 1385656859, no waits, latency 1 -> done pulses once, id_ok=1, ts_ok=1, timeout=0, 6-cycle latency.
REQ-034 Slave returns 8 for the ID -> id_ok=0, ts_ok=1, captured_id=8.
REQ-035 waitrequest held for 3 cycles on each read -> master_read/address stable throughout; both ok flags set to 1.
REQ-036 readdatavalid never asserted, TIMEOUT_CYCLES=10 -> timeout=1 after 10 cycles in the ID transaction, done pulses, id_ok=0, no timestamp read is issued.
REQ-037 start pulsed again during WAIT_ID -> ignored; exactly one done pulse.
REQ-038 reset asserted in WAIT_TS with a late readdatavalid -> all outputs 0, captured_timestamp remains 0.
